vector_sweep_checker: RTL
=========================

Name: vector_sweep_checker

Overview:
- Drives exhaustive input vectors into a small gate-level test circuit and checks the circuit's single output against a parameterised truth table.
- Sits on the other side of a test circuit's pins: stim_out feeds the circuit inputs, and the circuit output returns on resp_in.
- Provides a self-checking RTL reference for the circuits that the event-driven simulator evaluates.

Parameters:
- N_IN, 3, number of circuit inputs. Vector index i drives stim_out = i, with the MSB mapped to the first circuit input (A1).
- SETTLE_CYC, 4, wait cycles after a vector is applied before resp_in is sampled. Range 0..255.
- EXP_TT, 8'hFE, expected output per vector index. Bit i is the expected response for vector i. Width is 2**N_IN. The default encodes F = A|B|C.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a sweep; accepted only in IDLE
- resp_in  in  1  circuit output under test
- stim_out  out  N_IN  current input vector (registered)
- stim_valid  out  1  high while stim_out holds a vector under test
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the sweep completes
- pass  out  1  1 when the last sweep had zero mismatches
- err_count  out  N_IN+1  mismatch count of the last or current sweep
- first_err_idx  out  N_IN  vector index of the first mismatch
- first_err_vld  out  1  first_err_idx is meaningful

Behaviour:
- Reset, synchronous: state=IDLE.
  - stim_out=0, stim_valid=0, busy=0, done=0, pass=0.
  - err_count=0, first_err_idx=0, first_err_vld=0.
- Reset mid-sweep: abort immediately with the same values; no done pulse.
- States are IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - idx=0, stim_out=0, stim_valid=1, busy=1.
  - err_count=0, first_err_vld=0, pass=0.
  - Load settle counter with SETTLE_CYC.
  - Go to SETTLE, or straight to SAMPLE if SETTLE_CYC=0.
- SETTLE: decrement the counter each cycle; go to SAMPLE when the counter reaches 1.
- SAMPLE: compare resp_in with EXP_TT[idx].
  - On mismatch: err_count+1, saturating at 2**N_IN. If first_err_vld=0, capture idx into first_err_idx and set first_err_vld.
  - If idx == 2**N_IN-1, go to DONE.
  - Otherwise idx+1, update stim_out next cycle, reload the counter, and go to SETTLE (or SAMPLE if SETTLE_CYC=0).
- Each vector is held exactly SETTLE_CYC+1 cycles. resp_in is sampled in the last of those cycles.
- Sweep length is 2**N_IN*(SETTLE_CYC+1) cycles from the start edge to the DONE entry.
- DONE, one cycle:
  - done=1, busy=0, stim_valid=0.
  - stim_out holds the last vector.
  - pass = (final err_count==0).
  - Return to IDLE.
- pass, err_count and first_err_* hold until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- idx wrap cannot occur; termination is by comparison against 2**N_IN-1.

Optional Feature:
- Macro: VSC_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch in SAMPLE transfers directly to DONE.
  - stim_out stays frozen at the failing vector through DONE and IDLE until the next start.
  - err_count=1, pass=0.
- Undefined: the full sweep always runs and all mismatches are counted.

Test Plan:
1. Defaults, resp_in = OR of the stim_out bits, start at cycle 0.
   - done pulses after 40 cycles.
   - pass=1, err_count=0, first_err_vld=0.
2. Defaults, resp_in tied 1.
   - err_count=1, first_err_idx=0, pass=0.
3. Defaults, resp_in tied 0.
   - err_count=7, first_err_idx=1, pass=0.
4. SETTLE_CYC=0, correct model.
   - stim_out steps 0..7 on consecutive cycles.
   - done 8 cycles after start, pass=1.
5. Control checks, defaults:
   - Start pulse at cycle 10 mid-sweep: ignored, sweep still ends at cycle 40.
   - rst asserted at cycle 15: all outputs are reset values next cycle, no done pulse.
   - Fresh start afterwards: full 40-cycle sweep.
6. VSC_STOP_ON_ERR_EN defined, resp_in tied 0.
   - done at the end of vector 1's window (10 cycles).
   - stim_out=1, err_count=1, first_err_idx=1.

Source files
------------

// File: rtl/vector_sweep_checker_if.sv
// Pin-side bundle between vector_sweep_checker and the environment holding the circuit under test.
// slave: the checker itself; master: whatever issues start and returns the circuit response.
interface vector_sweep_checker_if #(
   parameter int unsigned N_IN = 3
);
   logic              start;
   logic              resp_in;
   logic [N_IN-1:0]   stim_out;
   logic              stim_valid;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   first_err_idx;
   logic              first_err_vld;

   modport slave (
      input  start, resp_in,
      output stim_out, stim_valid, busy, done, pass, err_count, first_err_idx, first_err_vld
   );

   modport master (
      output start, resp_in,
      input  stim_out, stim_valid, busy, done, pass, err_count, first_err_idx, first_err_vld
   );
endinterface

// File: rtl/vector_sweep_checker.sv
// Sweeps every input vector of a small circuit and checks its output against EXP_TT.
// Optional macro VSC_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module vector_sweep_checker #(
   parameter int unsigned            N_IN       = 3,
   parameter int unsigned            SETTLE_CYC = 4,
   parameter logic [(2**N_IN)-1:0]   EXP_TT     = 8'hFE
) (
   input logic                   clk,
   input logic                   rst,
   vector_sweep_checker_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [N_IN-1:0] LAST_IDX = '1;
   localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};
   localparam logic [7:0]      CNT_LOAD = 8'(SETTLE_CYC);
   localparam state_t          VEC_ST   = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

   state_t            state;
   logic [7:0]        cnt;
   logic [N_IN-1:0]   stim_q;
   logic              valid_q, busy_q, done_q, pass_q, fvld_q;
   logic [N_IN:0]     err_q;
   logic [N_IN-1:0]   fidx_q;

   logic              mism;
   logic              last;
   logic [N_IN:0]     err_nxt;

   always_comb begin
      mism    = bus.resp_in != EXP_TT[stim_q];
      err_nxt = err_q;
      if (mism && err_q != ERR_MAX) err_nxt = err_q + 1'b1;
   end

   // stim_q doubles as the vector index; it is never advanced past LAST_IDX
`ifdef VSC_STOP_ON_ERR_EN
   assign last = (stim_q == LAST_IDX) || mism;
`else
   assign last = (stim_q == LAST_IDX);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         stim_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fidx_q  <= '0;
         fvld_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  stim_q  <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  err_q   <= '0;
                  fvld_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  cnt     <= CNT_LOAD;
                  state   <= VEC_ST;
               end
            end
            SETTLE: begin
               if (cnt <= 8'd1) state <= SAMPLE;
               else             cnt   <= cnt - 8'd1;
            end
            SAMPLE: begin
               err_q <= err_nxt;
               if (mism && !fvld_q) begin
                  fidx_q <= stim_q;
                  fvld_q <= 1'b1;
               end
               if (last) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
                  pass_q  <= (err_nxt == '0);
                  state   <= DONE;
               end else begin
                  stim_q <= stim_q + 1'b1;
                  cnt    <= CNT_LOAD;
                  state  <= VEC_ST;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stim_out      = stim_q;
   assign bus.stim_valid    = valid_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_idx = fidx_q;
   assign bus.first_err_vld = fvld_q;

endmodule
